// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its IF/ID register.
// The decode stage imports the same field positions.
package if_stage_pkg;

  localparam logic [31:0] ResetPc  = 32'h0000_0000;
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic {
    StReq,
    StWait
  } fetch_state_e;

  localparam int unsigned OpcodeLsb = 0;
  localparam int unsigned RdLsb     = 7;
  localparam int unsigned Funct3Lsb = 12;
  localparam int unsigned Rs1Lsb    = 15;
  localparam int unsigned Rs2Lsb    = 20;
  localparam int unsigned Funct7Lsb = 25;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// Pipeline register with flush > hold > load > bubble priority.
// A bubble keeps the PC but replaces the instruction with a NOP.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        load_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc_d, pc_q;
  logic [31:0] instr_d, instr_q;
  logic        valid_d, valid_q;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = 32'h0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (hold_i) begin
      pc_d    = pc_q;
    end else if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, one-entry stall
// buffer, and redirect handling that drops responses still in flight.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = ResetPc,
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pipeline_stall,
  input  logic        PCSrc,
  input  logic [31:0] PC_Branch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_ID,
  output logic [31:0] INSTRUCTION_ID,
  output logic        VALID_ID
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  pc_inflight_d, pc_inflight_q;
  logic         drop_d, drop_q;
  logic         buf_valid_d, buf_valid_q;
  logic [31:0]  buf_pc_d, buf_pc_q;
  logic [31:0]  buf_instr_d, buf_instr_q;

  logic         rsp_live;
  logic         ifid_load;
  logic [31:0]  ifid_pc, ifid_instr;

  // Request is masked during reset so the memory never sees a fetch then.
  assign imem_req  = reset_n && (state_q == StReq) && !buf_valid_q;
  assign imem_addr = pc_q;

  assign rsp_live   = (state_q == StWait) && imem_rvalid && !drop_q;
  assign ifid_load  = buf_valid_q || rsp_live;
  assign ifid_pc    = buf_valid_q ? buf_pc_q : pc_inflight_q;
  assign ifid_instr = buf_valid_q ? buf_instr_q : imem_rdata;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_inflight_d = pc_inflight_q;
    drop_d        = drop_q;
    buf_valid_d   = buf_valid_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;

    unique case (state_q)
      StReq: begin
        if (imem_req && imem_gnt) begin
          pc_inflight_d = pc_q;
          pc_d          = pc_q + 32'd4;
          state_d       = StWait;
          drop_d        = PCSrc;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          state_d = StReq;
          drop_d  = 1'b0;
          if (!drop_q && !PCSrc && pipeline_stall) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = pc_inflight_q;
            buf_instr_d = imem_rdata;
          end
        end else if (PCSrc) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = StReq;
    endcase

    if (buf_valid_q && !PCSrc && !pipeline_stall) begin
      buf_valid_d = 1'b0;
    end

    // Redirect overrides both the sequential increment and any buffered work.
    if (PCSrc) begin
      pc_d        = word_align(PC_Branch);
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StReq;
      pc_q          <= RESET_PC;
      pc_inflight_q <= RESET_PC;
      drop_q        <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_pc_q      <= 32'h0;
      buf_instr_q   <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_inflight_q <= pc_inflight_d;
      drop_q        <= drop_d;
      buf_valid_q   <= buf_valid_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .flush_i(PCSrc),
    .hold_i (pipeline_stall),
    .load_i (ifid_load),
    .pc_i   (ifid_pc),
    .instr_i(ifid_instr),
    .pc_o   (PC_ID),
    .instr_o(INSTRUCTION_ID),
    .valid_o(VALID_ID)
  );

endmodule
